// File: rtl/disp_arbiter.sv
// disp_arbiter: shares one 8-digit display among alert (req[0]), stopwatch and time-of-day.
// Fixed priority for alert, round-robin between 1/2, minimum dwell; DISP_ARB_BLINK_EN adds alert blink.
module disp_arbiter #(
   parameter int TICK_DIV    = 50000,
   parameter int HOLD_TICKS  = 500
`ifdef DISP_ARB_BLINK_EN
   ,
   parameter int BLINK_TICKS = 250
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [2:0]  grant,
   output logic [31:0] sign,
   output logic        disp_en,
   output logic        busy
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   typedef enum logic {S_IDLE, S_OWN} state_t;
   state_t        r_state;
   logic [2:0]    r_grant;
   logic [31:0]   r_sign;
   logic          r_en, r_rr;
   logic [TW-1:0] r_tick;
   logic [HW-1:0] r_hold;
   logic          w_tick, w_done, w_chg, w_own_req, w_oth_req;
   logic [2:0]    w_sel, w_oth, w_nxt;
   logic [31:0]   w_data;
`ifdef DISP_ARB_BLINK_EN
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   logic [BW-1:0] r_blk;
   logic          w_blink;
`endif
   always_comb begin
      w_tick    = r_tick == TW'(TICK_DIV - 1);
      // dwell ends on the edge where the last tick lands, not one cycle later
      w_done    = (r_hold == '0) || (r_hold == HW'(1) && w_tick);
      w_own_req = |(req & r_grant);
      w_oth     = r_grant ^ 3'b110;
      w_oth_req = |(req & w_oth);
      w_sel     = req[0] ? 3'b001 :
                  r_rr   ? (req[2] ? 3'b100 : {1'b0, req[1], 1'b0}) :
                           (req[1] ? 3'b010 : {req[2], 2'b00});
      w_nxt     = (r_state == S_IDLE)                ? w_sel :
                  (req[0] && !r_grant[0])            ? 3'b001 :
                  (w_done && !w_own_req)             ? w_sel :
                  (w_done && !r_grant[0] && w_oth_req) ? w_oth : r_grant;
      w_chg     = w_nxt != r_grant;
      w_data    = ({32{w_nxt[0]}} & data0) | ({32{w_nxt[1]}} & data1) | ({32{w_nxt[2]}} & data2);
`ifdef DISP_ARB_BLINK_EN
      w_blink   = w_tick && r_blk == BW'(BLINK_TICKS - 1);
`endif
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_sign  <= '0;
         r_en    <= 1'b0;
         r_rr    <= 1'b0;
         r_tick  <= '0;
         r_hold  <= '0;
`ifdef DISP_ARB_BLINK_EN
         r_blk   <= '0;
`endif
      end else begin
         r_state <= (|w_nxt) ? S_OWN : S_IDLE;
         r_grant <= w_nxt;
         r_sign  <= (w_chg || w_own_req) ? w_data : r_sign;
         r_tick  <= (w_chg || w_tick) ? '0 : r_tick + 1'b1;
         r_hold  <= w_chg ? HW'(HOLD_TICKS) : (w_tick && r_hold != '0) ? r_hold - 1'b1 : r_hold;
         r_rr    <= (w_chg && w_nxt[1]) ? 1'b1 : (w_chg && w_nxt[2]) ? 1'b0 : r_rr;
`ifdef DISP_ARB_BLINK_EN
         r_blk   <= (w_chg || w_blink) ? '0 : w_tick ? r_blk + 1'b1 : r_blk;
         r_en    <= (w_chg || !w_nxt[0]) ? |w_nxt : w_blink ? !r_en : r_en;
`else
         r_en    <= |w_nxt;
`endif
      end
   end
   assign grant   = r_grant;
   assign sign    = r_sign;
   assign disp_en = r_en;
   assign busy    = r_state == S_OWN;
endmodule
